// File: rtl/intr_arbiter.sv
// Multi-source interrupt controller: edge-detects sources into pending flags, masks them,
// and drives one prioritized request through a REQ -> SERVICE -> IDLE handshake.

module intr_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic pend
);
  logic src_q;

  // A new rise beats a same-cycle acknowledge clear so that event is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      src_q <= src;
      pend  <= (src & ~src_q) | (pend & ~clr);
    end
  end
endmodule

module intr_arbiter #(
  parameter int              NSRC        = 4,
  parameter int              IDW         = 2,
  parameter logic [NSRC-1:0] RESET_MASK  = {NSRC{1'b1}},
  parameter int              ACK_TIMEOUT = 255,
  parameter int              TO_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_din,
  input  logic            interrupt_ack,
  input  logic            eoi,
  input  logic            err_clr,
  output logic            interrupt,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic            in_service,
  output logic            timeout_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = (ACK_TIMEOUT == 0) ? '0 : TO_W'(ACK_TIMEOUT - 1);

  logic [1:0]      state;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  win;
  logic [TO_W-1:0] cnt;
  logic            ack_hit;
  logic            to_hit;

  assign ack_hit = (state == S_REQ) && interrupt_ack;
  assign to_hit  = (ACK_TIMEOUT != 0) && (state == S_REQ) && !interrupt_ack && (cnt == TO_LAST);
  assign elig    = pending & mask;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign clr[g] = ack_hit && (irq_id == IDW'(g));
    intr_src_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .src   (src[g]),
      .clr   (clr[g]),
      .pend  (pending[g])
    );
  end

  // Lowest eligible index wins.
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (elig[i]) win = IDW'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      mask        <= RESET_MASK;
      interrupt   <= 1'b0;
      irq_id      <= '0;
      in_service  <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      if (mask_we) mask <= mask_din;

      if (to_hit)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      case (state)
        S_IDLE: if (|elig) begin
          state     <= S_REQ;
          irq_id    <= win;
          interrupt <= 1'b1;
          cnt       <= '0;
        end
        S_REQ: begin
          cnt <= cnt + TO_W'(1);
          if (interrupt_ack) begin
            state      <= S_SVC;
            interrupt  <= 1'b0;
            in_service <= 1'b1;
          end else if (to_hit) begin
            state     <= S_IDLE;
            interrupt <= 1'b0;
          end
        end
        S_SVC: if (eoi) begin
          state      <= S_IDLE;
          in_service <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intr_arbiter.sv
// Scoreboard bench for intr_arbiter: expected output snapshots are queued with each
// stimulus step and compared one cycle later, after the clock edge.

module tb_intr_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] src = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_din = '0;
  logic       interrupt_ack = 1'b0;
  logic       eoi = 1'b0;
  logic       err_clr = 1'b0;
  logic       interrupt;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       in_service;
  logic       timeout_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend;
    logic       svc;
    logic       err;
  } exp_t;

  exp_t sb[$];

  intr_arbiter #(
    .NSRC(4), .IDW(2), .RESET_MASK(4'b1111), .ACK_TIMEOUT(4), .TO_W(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src           (src),
    .mask_we       (mask_we),
    .mask_din      (mask_din),
    .interrupt_ack (interrupt_ack),
    .eoi           (eoi),
    .err_clr       (err_clr),
    .interrupt     (interrupt),
    .irq_id        (irq_id),
    .pending       (pending),
    .in_service    (in_service),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ex(input string tag, input logic irq, input logic [1:0] id,
                    input logic [3:0] pend, input logic svc, input logic err);
    exp_t e;
    e.tag = tag; e.irq = irq; e.id = id; e.pend = pend; e.svc = svc; e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic irq, input logic [1:0] id,
                           input logic [3:0] pend, input logic svc, input logic err);
    chk({tag, ".irq"}, 8'(interrupt), 8'(irq));
    chk({tag, ".id"},  8'(irq_id),    8'(id));
    chk({tag, ".pend"}, 8'(pending),  8'(pend));
    chk({tag, ".svc"}, 8'(in_service), 8'(svc));
    chk({tag, ".err"}, 8'(timeout_err), 8'(err));
  endtask

  // Advance one edge, then retire every expectation queued for it.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_now(e.tag, e.irq, e.id, e.pend, e.svc, e.err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check_now("rst", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;

    // single event on source 2
    src = 4'b0100;
    ex("t1_e0", 0, 2'd0, 4'b0100, 0, 0); cyc();
    ex("t1_e1", 1, 2'd2, 4'b0100, 0, 0); cyc();
    ex("t1_e2", 1, 2'd2, 4'b0100, 0, 0); cyc();
    interrupt_ack = 1'b1;
    ex("t1_ack", 0, 2'd2, 4'b0000, 1, 0); cyc();
    interrupt_ack = 1'b0;
    ex("t1_svc", 0, 2'd2, 4'b0000, 1, 0); cyc();
    eoi = 1'b1;
    ex("t1_eoi", 0, 2'd2, 4'b0000, 0, 0); cyc();
    eoi = 1'b0;
    ex("t1_idle", 0, 2'd2, 4'b0000, 0, 0); cyc();
    src = 4'b0000; cyc();

    // priority: 1 before 3, one idle cycle between requests
    src = 4'b1010;
    ex("t2_e0", 0, 2'd2, 4'b1010, 0, 0); cyc();
    ex("t2_req1", 1, 2'd1, 4'b1010, 0, 0); cyc();
    interrupt_ack = 1'b1;
    ex("t2_ack1", 0, 2'd1, 4'b1000, 1, 0); cyc();
    interrupt_ack = 1'b0; eoi = 1'b1;
    ex("t2_eoi1", 0, 2'd1, 4'b1000, 0, 0); cyc();
    eoi = 1'b0;
    ex("t2_req3", 1, 2'd3, 4'b1000, 0, 0); cyc();
    interrupt_ack = 1'b1;
    ex("t2_ack3", 0, 2'd3, 4'b0000, 1, 0); cyc();
    interrupt_ack = 1'b0; eoi = 1'b1;
    ex("t2_eoi3", 0, 2'd3, 4'b0000, 0, 0); cyc();
    eoi = 1'b0; src = 4'b0000; cyc();

    // mask holds off source 1 until re-enabled
    mask_we = 1'b1; mask_din = 4'b1101; cyc();
    mask_we = 1'b0; src = 4'b0010;
    ex("t3_msk0", 0, 2'd3, 4'b0010, 0, 0); cyc();
    ex("t3_msk1", 0, 2'd3, 4'b0010, 0, 0); cyc();
    ex("t3_msk2", 0, 2'd3, 4'b0010, 0, 0); cyc();
    mask_we = 1'b1; mask_din = 4'b1111;
    ex("t3_wr", 0, 2'd3, 4'b0010, 0, 0); cyc();
    mask_we = 1'b0;
    ex("t3_req", 1, 2'd1, 4'b0010, 0, 0); cyc();
    interrupt_ack = 1'b1;
    ex("t3_ack", 0, 2'd1, 4'b0000, 1, 0); cyc();
    interrupt_ack = 1'b0; eoi = 1'b1;
    ex("t3_eoi", 0, 2'd1, 4'b0000, 0, 0); cyc();
    eoi = 1'b0; src = 4'b0000; cyc();

    // new rise on source 0 in the same cycle as its ack
    src = 4'b0001;
    ex("t4_e0", 0, 2'd1, 4'b0001, 0, 0); cyc();
    src = 4'b0000;
    ex("t4_req", 1, 2'd0, 4'b0001, 0, 0); cyc();
    src = 4'b0001; interrupt_ack = 1'b1;
    ex("t4_coll", 0, 2'd0, 4'b0001, 1, 0); cyc();
    src = 4'b0000; interrupt_ack = 1'b0; eoi = 1'b1;
    ex("t4_eoi", 0, 2'd0, 4'b0001, 0, 0); cyc();
    eoi = 1'b0;
    ex("t4_req2", 1, 2'd0, 4'b0001, 0, 0); cyc();
    interrupt_ack = 1'b1;
    ex("t4_ack2", 0, 2'd0, 4'b0000, 1, 0); cyc();
    interrupt_ack = 1'b0; eoi = 1'b1;
    ex("t4_eoi2", 0, 2'd0, 4'b0000, 0, 0); cyc();
    eoi = 1'b0; cyc();

    // ack timeout after exactly 4 request cycles
    src = 4'b0100;
    ex("t5_e0", 0, 2'd0, 4'b0100, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      ex($sformatf("t5_hi%0d", i), 1, 2'd2, 4'b0100, 0, 0); cyc();
    end
    ex("t5_drop", 0, 2'd2, 4'b0100, 0, 1); cyc();
    ex("t5_rereq", 1, 2'd2, 4'b0100, 0, 1); cyc();
    err_clr = 1'b1;
    ex("t5_clr", 1, 2'd2, 4'b0100, 0, 0); cyc();
    err_clr = 1'b0; interrupt_ack = 1'b1;
    ex("t5_ack", 0, 2'd2, 4'b0000, 1, 0); cyc();
    interrupt_ack = 1'b0; eoi = 1'b1;
    ex("t5_eoi", 0, 2'd2, 4'b0000, 0, 0); cyc();
    eoi = 1'b0; src = 4'b0000; cyc();

    // async reset during REQ, with the source masked off meanwhile
    src = 4'b0001;
    ex("t6_e0", 0, 2'd2, 4'b0001, 0, 0); cyc();
    mask_we = 1'b1; mask_din = 4'b0000;
    ex("t6_req", 1, 2'd0, 4'b0001, 0, 0); cyc();
    mask_we = 1'b0;
    ex("t6_keep", 1, 2'd0, 4'b0001, 0, 0); cyc();
    #2 reset = 1'b0; src = 4'b0000;
    #1 check_now("t6_rst_req", 0, 2'd0, 4'b0000, 0, 0);
    #2 reset = 1'b1;
    src = 4'b0001;
    ex("t6_e0b", 0, 2'd0, 4'b0001, 0, 0); cyc();
    ex("t6_mask_rst", 1, 2'd0, 4'b0001, 0, 0); cyc();
    interrupt_ack = 1'b1;
    ex("t6_svc", 0, 2'd0, 4'b0000, 1, 0); cyc();
    interrupt_ack = 1'b0;
    #2 reset = 1'b0;
    #1 check_now("t6_rst_svc", 0, 2'd0, 4'b0000, 0, 0);
    #2 reset = 1'b1; src = 4'b0000;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
